// File: rtl/bist_sequencer.sv
// bist_sequencer: runs N_SESSIONS back-to-back BIST sessions (INIT, RUN, FINISH),
// compares the MISR signature against a golden value at the end of every session
// and reports sticky pass/fail, the first failing session, abort and end status.
module bist_sequencer #(
    parameter int NCLOCK     = 650,
    parameter int N_SESSIONS = 4,
    parameter int SIG_W      = 16,
    parameter int CNT_W      = $clog2(NCLOCK + 1),
    parameter int IDX_W      = (N_SESSIONS > 1) ? $clog2(N_SESSIONS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_ncycles,
    input  logic [SIG_W-1:0] sig_in,
    input  logic [SIG_W-1:0] golden_in,
    output logic [IDX_W-1:0] session_idx,
    output logic             init,
    output logic             running,
    output logic             toggle,
    output logic             finish,
    output logic             busy,
    output logic             bist_end,
    output logic             pass,
    output logic [IDX_W-1:0] fail_idx,
    output logic             aborted
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_RUN    = 3'd2,
        ST_FINISH = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SESSIONS - 1);
    localparam logic [CNT_W-1:0] DEF_LEN  = CNT_W'(NCLOCK);

    state_t           state_q, state_d;
    logic             start_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] fidx_q, fidx_d;
    logic             fail_q, fail_d;
    logic             abrt_q, abrt_d;

    logic             edge_s;
    logic             busy_s;
    logic             accept_s;

    assign edge_s   = start & ~start_q;
    assign busy_s   = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_FINISH);
    // A start edge coinciding with abort is dropped even when idle.
    assign accept_s = edge_s & ~abort & ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Start edge detector; resets high so a start held through reset is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b1;
        end else begin
            start_q <= start;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            len_q   <= {CNT_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            fidx_q  <= {IDX_W{1'b0}};
            fail_q  <= 1'b0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            fidx_q  <= fidx_d;
            fail_q  <= fail_d;
            abrt_q  <= abrt_d;
        end
    end

    // Next-state and next-datapath logic; abort overrides every busy state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        idx_d   = idx_q;
        fidx_d  = fidx_q;
        fail_d  = fail_q;
        abrt_d  = abrt_q;
        if (abort && busy_s) begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            idx_d   = {IDX_W{1'b0}};
            abrt_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        state_d = ST_INIT;
                        cnt_d   = {CNT_W{1'b0}};
                        idx_d   = {IDX_W{1'b0}};
                        fidx_d  = {IDX_W{1'b0}};
                        fail_d  = 1'b0;
                        abrt_d  = 1'b0;
                        len_d   = (cfg_ncycles == {CNT_W{1'b0}}) ? DEF_LEN : cfg_ncycles;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_INIT: begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end
                ST_RUN: begin
                    if (cnt_q == (len_q - CNT_W'(1))) begin
                        state_d = ST_FINISH;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                ST_FINISH: begin
                    // Only the first mismatching session is recorded.
                    if ((sig_in != golden_in) && !fail_q) begin
                        fail_d = 1'b1;
                        fidx_d = idx_q;
                    end else begin
                        fail_d = fail_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_INIT;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Moore outputs decoded from registered state; toggle follows counter parity.
    assign init        = (state_q == ST_INIT);
    assign running     = (state_q == ST_RUN);
    assign toggle      = (state_q == ST_RUN) & ~cnt_q[0];
    assign finish      = (state_q == ST_FINISH);
    assign busy        = busy_s;
    assign bist_end    = (state_q == ST_DONE);
    assign pass        = (state_q == ST_DONE) & ~fail_q;
    assign session_idx = idx_q;
    assign fail_idx    = fidx_q;
    assign aborted     = abrt_q;

endmodule
